hub_copy: RTL and testbench

//  Hub-bus initiator: block-copies longs between hub addresses by driving the
//  hub memory port (w/wb/a/d out, q in) under the ena_bus slot strobe.

---
 rtl/hub_copy.sv | 155 +++++++++++++++
 tb/tb_hub_copy.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hub_copy.sv
// Hub-bus block copier: moves longs from src to dst through the hub memory port.
// Optional HUB_COPY_FILL_EN adds a pattern-fill mode (ports fill/pat).
module hub_copy #(
  parameter int AW = 14,
  parameter int CW = 14
) (
  input  logic          clk_cog,
  input  logic          nres,
  input  logic          start,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [CW-1:0] cnt,
  input  logic          abort,
`ifdef HUB_COPY_FILL_EN
  input  logic          fill,
  input  logic [31:0]   pat,
`endif
  output logic          busy,
  output logic          done,
  input  logic          ena_bus,
  input  logic [31:0]   q,
  output logic          w,
  output logic [3:0]    wb,
  output logic [AW-1:0] a,
  output logic [31:0]   d,
  output logic [1:0]    dbg_state
);

  // Bus handshake: a/w/wb/d are held stable until a rising edge with
  // ena_bus=1; that edge commits the op, and read data on q is valid from
  // the following cycle until the next ena_bus edge.
  typedef enum logic [1:0] {S_IDLE, S_RD, S_CAP, S_WR} state_t;

  localparam logic [CW-1:0] ONE = CW'(1);

  state_t        state_q;
  logic          busy_q;
  logic          done_q;
  logic          w_q;
  logic [3:0]    wb_q;
  logic [AW-1:0] a_q;
  logic [31:0]   d_q;
  logic [AW-1:0] src_ptr_q;
  logic [AW-1:0] dst_ptr_q;
  logic [CW-1:0] rem_q;
`ifdef HUB_COPY_FILL_EN
  logic          fill_q;
`endif

  // d_q doubles as the data buffer: it holds the captured long through WR.
  always_ff @(posedge clk_cog or negedge nres) begin
    if (!nres) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      w_q       <= 1'b0;
      wb_q      <= 4'h0;
      a_q       <= '0;
      d_q       <= '0;
      src_ptr_q <= '0;
      dst_ptr_q <= '0;
      rem_q     <= '0;
`ifdef HUB_COPY_FILL_EN
      fill_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (state_q != S_IDLE && abort) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
        w_q     <= 1'b0;
        wb_q    <= 4'h0;
        a_q     <= '0;
        d_q     <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start && !abort) begin
              if (cnt != '0) begin
                src_ptr_q <= src;
                dst_ptr_q <= dst;
                rem_q     <= cnt;
                busy_q    <= 1'b1;
`ifdef HUB_COPY_FILL_EN
                fill_q    <= fill;
                if (fill) begin
                  d_q     <= pat;
                  a_q     <= dst;
                  w_q     <= 1'b1;
                  wb_q    <= 4'hF;
                  state_q <= S_WR;
                end else
`endif
                begin
                  a_q     <= src;
                  state_q <= S_RD;
                end
              end else begin
                done_q <= 1'b1;
              end
            end
          end
          S_RD: begin
            if (ena_bus) state_q <= S_CAP;
          end
          S_CAP: begin
            d_q     <= q;
            a_q     <= dst_ptr_q;
            w_q     <= 1'b1;
            wb_q    <= 4'hF;
            state_q <= S_WR;
          end
          S_WR: begin
            if (ena_bus) begin
              src_ptr_q <= src_ptr_q + 1'b1;
              dst_ptr_q <= dst_ptr_q + 1'b1;
              rem_q     <= rem_q - 1'b1;
              if (rem_q == ONE) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                w_q     <= 1'b0;
                wb_q    <= 4'h0;
                a_q     <= '0;
                d_q     <= '0;
              end else
`ifdef HUB_COPY_FILL_EN
              if (fill_q) begin
                a_q <= dst_ptr_q + 1'b1;
              end else
`endif
              begin
                a_q     <= src_ptr_q + 1'b1;
                w_q     <= 1'b0;
                wb_q    <= 4'h0;
                d_q     <= '0;
                state_q <= S_RD;
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign w         = w_q;
  assign wb        = wb_q;
  assign a         = a_q;
  assign d         = d_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_hub_copy.sv
// Bench for hub_copy: hub memory model, write scoreboard and a sequential
// reference copy over a shadow memory.
module tb_hub_copy;
  localparam int AW    = 14;
  localparam int CW    = 14;
  localparam int DEPTH = 1 << AW;
  localparam int W     = AW + 32;
  localparam int BOUND = 2000;

  logic          clk_cog = 1'b0;
  logic          nres    = 1'b0;
  logic          start   = 1'b0;
  logic          abort   = 1'b0;
  logic          ena_bus = 1'b0;
  logic [AW-1:0] src     = '0;
  logic [AW-1:0] dst     = '0;
  logic [CW-1:0] cnt     = '0;
  logic [31:0]   q       = '0;
  logic          busy, done, w;
  logic [3:0]    wb;
  logic [AW-1:0] a;
  logic [31:0]   d;
  logic [1:0]    dbg_state;
`ifdef HUB_COPY_FILL_EN
  logic          fill = 1'b0;
  logic [31:0]   pat  = '0;
`endif

  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  logic [W-1:0] exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int commits = 0;
  int last_commit = 0;
  int ena_mode = 0;

  hub_copy #(.AW(AW), .CW(CW)) dut (
    .clk_cog(clk_cog), .nres(nres), .start(start), .src(src), .dst(dst),
    .cnt(cnt), .abort(abort),
`ifdef HUB_COPY_FILL_EN
    .fill(fill), .pat(pat),
`endif
    .busy(busy), .done(done), .ena_bus(ena_bus), .q(q), .w(w), .wb(wb),
    .a(a), .d(d), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk_cog = ~clk_cog;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // ena_bus strobe patterns: 0 always on, 1 one-in-eight, 2 random
  always @(negedge clk_cog) begin
    case (ena_mode)
      0:       ena_bus = 1'b1;
      1:       ena_bus = (cyc % 8 == 0);
      default: ena_bus = ($urandom_range(0, 2) == 0);
    endcase
  end

  // hub memory model plus write scoreboard; ROM half ignores writes
  always @(posedge clk_cog) begin
    cyc++;
    if (ena_bus) begin
      q <= mem[a];
      if (busy) begin
        commits++;
        last_commit = cyc;
      end
      if (w) begin
        if (a < AW'('h2000)) begin
          for (int b = 0; b < 4; b++)
            if (wb[b]) mem[a][8*b +: 8] <= d[8*b +: 8];
        end
        check("wr_wb", 64'(wb), 64'(4'hF));
        if (exp_q.size() == 0) check("wr_unexpected", 64'(exp_q.size()), 64'(1));
        else check("wr_data", 64'({a, d}), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic cmp_mem(input string tag);
    int diffs = 0;
    for (int i = 0; i < DEPTH; i++)
      if (mem[i] !== ref_mem[i]) diffs++;
    check(tag, 64'(diffs), 64'(0));
  endtask

  // reference: strictly ascending long-by-long copy (or fill) over ref_mem
  task automatic model_copy(input logic [AW-1:0] s, input logic [AW-1:0] dd,
                            input int n, input bit fl, input logic [31:0] p);
    logic [AW-1:0] sa, da;
    logic [31:0] v;
    for (int i = 0; i < n; i++) begin
      sa = s + AW'(i);
      da = dd + AW'(i);
      v  = fl ? p : ref_mem[sa];
      exp_q.push_back({da, v});
      if (da < AW'('h2000)) ref_mem[da] = v;
    end
  endtask

  task automatic run_copy(input logic [AW-1:0] s, input logic [AW-1:0] dd,
                          input logic [CW-1:0] n, input int mode, input bit fl,
                          input logic [31:0] p, input bit poke);
    int k = 0;
    ena_mode = mode;
    model_copy(s, dd, int'(n), fl, p);
    @(negedge clk_cog);
    start = 1'b1; src = s; dst = dd; cnt = n;
`ifdef HUB_COPY_FILL_EN
    fill = fl; pat = p;
`endif
    @(negedge clk_cog);
    commits = 0;
    start = 1'b0;
    src = AW'($urandom); dst = AW'($urandom); cnt = CW'($urandom);
`ifdef HUB_COPY_FILL_EN
    fill = 1'b0; pat = $urandom;
`endif
    check("busy_up", 64'(busy), 64'(1));
    while (!done && k < BOUND) begin
      if (poke && k == 0) begin
        start = 1'b1;
        cnt = CW'($urandom_range(1, 9));
      end else begin
        start = 1'b0;
      end
      @(negedge clk_cog);
      k++;
    end
    start = 1'b0;
    check("done_seen", 64'(done), 64'(1));
    check("busy_at_done", 64'(busy), 64'(0));
    if (mode == 0) check("latency", 64'(k), 64'(fl ? int'(n) : 3 * int'(n)));
    if (mode == 1) begin
      check("commits", 64'(commits), 64'(fl ? int'(n) : 2 * int'(n)));
      check("done_after_commit", 64'(cyc), 64'(last_commit));
    end
    @(negedge clk_cog);
    check("done_pulse", 64'(done), 64'(0));
    check("idle_w", 64'(w), 64'(0));
    check("idle_a", 64'(a), 64'(0));
    check("busy_idle", 64'(busy), 64'(0));
    check("exp_q_empty", 64'(exp_q.size()), 64'(0));
    exp_q.delete();
    cmp_mem("mem");
  endtask

  initial begin
    bit saw_done;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    for (int i = 0; i < 4; i++) begin
      mem[10 + i] = 32'hA0 + 32'(i);
      ref_mem[10 + i] = mem[10 + i];
    end
    repeat (2) @(negedge clk_cog);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_bus", 64'({w, wb, a, d}), 64'(0));
    nres = 1'b1;
    @(negedge clk_cog);

    // basic copy, sparse strobe, pointer wrap
    run_copy(14'd10, 14'd40, 14'd4, 0, 1'b0, 32'h0, 1'b0);
    run_copy(14'd50, 14'd60, 14'd2, 1, 1'b0, 32'h0, 1'b0);
    run_copy(14'h3FFE, 14'h0100, 14'd3, 0, 1'b0, 32'h0, 1'b0);

    // zero count: done next cycle, no bus activity
    ena_mode = 0;
    @(negedge clk_cog);
    start = 1'b1; cnt = '0; src = 14'd5; dst = 14'd6;
    @(negedge clk_cog);
    start = 1'b0;
    check("cnt0_done", 64'(done), 64'(1));
    check("cnt0_busy", 64'(busy), 64'(0));
    @(negedge clk_cog);
    check("cnt0_done_low", 64'(done), 64'(0));

    // abort beats start in IDLE
    start = 1'b1; abort = 1'b1; cnt = 14'd3;
    @(negedge clk_cog);
    start = 1'b0; abort = 1'b0;
    check("abort_start_busy", 64'(busy), 64'(0));
    check("abort_start_done", 64'(done), 64'(0));

    // abort in second RD: one long written
    model_copy(14'd100, 14'd200, 1, 1'b0, 32'h0);
    start = 1'b1; src = 14'd100; dst = 14'd200; cnt = 14'd4;
    @(negedge clk_cog);
    start = 1'b0;
    repeat (3) @(negedge clk_cog);
    abort = 1'b1;
    @(negedge clk_cog);
    abort = 1'b0;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_bus", 64'({w, wb, a, d}), 64'(0));
    saw_done = done;
    repeat (3) begin
      @(negedge clk_cog);
      saw_done |= done;
    end
    check("abort_no_done", 64'(saw_done), 64'(0));
    check("abort_exp_q", 64'(exp_q.size()), 64'(0));
    exp_q.delete();
    cmp_mem("abort_mem");

    // reset asserted in second WR: one long written
    model_copy(14'd300, 14'd400, 1, 1'b0, 32'h0);
    start = 1'b1; src = 14'd300; dst = 14'd400; cnt = 14'd4;
    @(negedge clk_cog);
    start = 1'b0;
    repeat (5) @(negedge clk_cog);
    check("pre_rst_w", 64'(w), 64'(1));
    nres = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_bus", 64'({done, w, wb, a, d}), 64'(0));
    @(negedge clk_cog);
    nres = 1'b1;
    @(negedge clk_cog);
    check("postrst_done", 64'(done), 64'(0));
    check("rst_exp_q", 64'(exp_q.size()), 64'(0));
    exp_q.delete();
    cmp_mem("rst_mem");

`ifdef HUB_COPY_FILL_EN
    run_copy(14'd7, 14'd20, 14'd5, 0, 1'b1, 32'hDEADBEEF, 1'b0);
    run_copy(14'd7, 14'h3FFF, 14'd3, 1, 1'b1, 32'h12345678, 1'b0);
`endif

    // randomized transfers, strobe patterns and ignored mid-transfer starts
    for (int t = 0; t < 25; t++) begin
      bit fl = 1'b0;
`ifdef HUB_COPY_FILL_EN
      fl = 1'($urandom_range(0, 1));
`endif
      run_copy(AW'($urandom), AW'($urandom), CW'($urandom_range(1, 8)),
               $urandom_range(0, 2), fl && 1'b1 ? fl : 1'b0, $urandom,
               fl ? 1'b0 : 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", n_cmp, n_bad);
    $finish;
  end

endmodule
